// File: rtl/bus_transaction_logic.sv
// Single-outstanding bus master: turns a registered controller command into
// aligned bus strobes, waits for a single-cycle ack, and abandons after a timeout.

package transactionGroup;
    typedef enum logic [3:0] {
        NO_OP       = 4'd0,
        READ        = 4'd1,
        WRITE_BYTE0 = 4'd2,
        WRITE_BYTE1 = 4'd3,
        WRITE_BYTE2 = 4'd4,
        WRITE_BYTE3 = 4'd5,
        WRITE_WORD0 = 4'd6,
        WRITE_WORD1 = 4'd7,
        WRITE_DWORD = 4'd8
    } controlBus;
endpackage

module bus_transaction_logic #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  transactionGroup::controlBus transactionControl,
    input  logic [31:0]                 address,
    input  logic [31:0]                 writeData,
    output logic [29:0]                 busAddress,
    output logic [3:0]                  busByteEnable,
    output logic                        busRead,
    output logic                        busWrite,
    output logic [31:0]                 busWriteData,
    input  logic [31:0]                 busReadData,
    input  logic                        busAck,
    output logic [31:0]                 readData,
    output logic                        readValid,
    output logic                        stall,
    output logic                        busTimeout
);
    import transactionGroup::*;

    typedef enum logic {IDLE, BUS} state_t;
    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [7:0]  count_reg;
    logic [29:0] bus_address_reg;
    logic [3:0]  bus_be_reg;
    logic        bus_read_reg;
    logic        bus_write_reg;
    logic [31:0] bus_wdata_reg;
    logic [31:0] read_data_reg;
    logic        read_valid_reg;
    logic        bus_timeout_reg;

    logic        cmd_valid;
    logic        timeout_hit;
    logic [3:0]  be_next;
    logic        rd_next;
    logic        wr_next;
    size_t       size_next;
    logic [31:0] wdata_next;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];

    // Encodings outside the defined command set are treated like NO_OP.
    assign cmd_valid   = (transactionControl != NO_OP) && (transactionControl <= WRITE_DWORD);
    assign timeout_hit = (count_reg == LAST_COUNT);

    always_comb begin
        be_next   = 4'b0000;
        rd_next   = 1'b0;
        wr_next   = 1'b0;
        size_next = SZ_NONE;
        case (transactionControl)
            READ:        begin be_next = 4'b1111; rd_next = 1'b1; end
            WRITE_BYTE0: begin be_next = 4'b0001; wr_next = 1'b1; size_next = SZ_BYTE; end
            WRITE_BYTE1: begin be_next = 4'b0010; wr_next = 1'b1; size_next = SZ_BYTE; end
            WRITE_BYTE2: begin be_next = 4'b0100; wr_next = 1'b1; size_next = SZ_BYTE; end
            WRITE_BYTE3: begin be_next = 4'b1000; wr_next = 1'b1; size_next = SZ_BYTE; end
            WRITE_WORD0: begin be_next = 4'b0011; wr_next = 1'b1; size_next = SZ_HALF; end
            WRITE_WORD1: begin be_next = 4'b1100; wr_next = 1'b1; size_next = SZ_HALF; end
            WRITE_DWORD: begin be_next = 4'b1111; wr_next = 1'b1; size_next = SZ_WORD; end
            default:     ;
        endcase
    end

    // Each lane picks the source byte matching the access size (replication).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_next[gi*8 +: 8] =
                (size_next == SZ_BYTE) ? writeData[7:0] :
                (size_next == SZ_HALF) ? writeData[(gi % 2)*8 +: 8] :
                (size_next == SZ_WORD) ? writeData[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            bus_address_reg <= '0;
            bus_be_reg      <= '0;
            bus_read_reg    <= 1'b0;
            bus_write_reg   <= 1'b0;
            bus_wdata_reg   <= '0;
            read_data_reg   <= '0;
            read_valid_reg  <= 1'b0;
            bus_timeout_reg <= 1'b0;
        end else begin
            read_valid_reg  <= 1'b0;
            bus_timeout_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (cmd_valid) begin
                    state_reg       <= BUS;
                    count_reg       <= '0;
                    bus_address_reg <= address[31:2];
                    bus_be_reg      <= be_next;
                    bus_read_reg    <= rd_next;
                    bus_write_reg   <= wr_next;
                    bus_wdata_reg   <= wdata_next;
                end
            end else if (busAck || timeout_hit) begin
                // An ack coinciding with the last allowed cycle wins over the timeout.
                state_reg       <= IDLE;
                count_reg       <= '0;
                bus_address_reg <= '0;
                bus_be_reg      <= '0;
                bus_read_reg    <= 1'b0;
                bus_write_reg   <= 1'b0;
                bus_wdata_reg   <= '0;
                if (busAck && bus_read_reg) begin
                    read_data_reg  <= busReadData;
                    read_valid_reg <= 1'b1;
                end
                bus_timeout_reg <= !busAck;
            end else begin
                count_reg <= count_reg + 8'd1;
            end
        end
    end

    assign stall = reset && (((state_reg == IDLE) && cmd_valid) ||
                             ((state_reg == BUS) && !busAck && !timeout_hit));

    assign busAddress    = bus_address_reg;
    assign busByteEnable = bus_be_reg;
    assign busRead       = bus_read_reg;
    assign busWrite      = bus_write_reg;
    assign busWriteData  = bus_wdata_reg;
    assign readData      = read_data_reg;
    assign readValid     = read_valid_reg;
    assign busTimeout    = bus_timeout_reg;

endmodule

// File: tb/tb_bus_transaction_logic.sv
// Directed and randomized transactions checked cycle by cycle against a
// transaction-level reference model of the bus master.
module tb_bus_transaction_logic;
    import transactionGroup::*;

    localparam int T = 4;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        reset;
    controlBus   transactionControl;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [29:0] busAddress;
    logic [3:0]  busByteEnable;
    logic        busRead;
    logic        busWrite;
    logic [31:0] busWriteData;
    logic [31:0] busReadData;
    logic        busAck;
    logic [31:0] readData;
    logic        readValid;
    logic        stall;
    logic        busTimeout;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'h0;
    logic        exp_rv = 1'b0;
    logic        exp_to = 1'b0;

    always #5 clk = ~clk;

    bus_transaction_logic #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .transactionControl(transactionControl),
        .address(address), .writeData(writeData), .busAddress(busAddress),
        .busByteEnable(busByteEnable), .busRead(busRead), .busWrite(busWrite),
        .busWriteData(busWriteData), .busReadData(busReadData), .busAck(busAck),
        .readData(readData), .readValid(readValid), .stall(stall),
        .busTimeout(busTimeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: lanes and data derived from access size and lane index.
    function automatic logic [3:0] exp_be(input controlBus c);
        int n;
        n = int'(c);
        if (c == READ || c == WRITE_DWORD) return 4'b1111;
        if (n >= 2 && n <= 5) return 4'(1 << (n - 2));
        if (n == 6 || n == 7) return 4'(3 << (2 * (n - 6)));
        return 4'b0000;
    endfunction

    function automatic logic [31:0] exp_wdata(input controlBus c, input logic [31:0] wd);
        int n;
        n = int'(c);
        if (n >= 2 && n <= 5) return {4{wd[7:0]}};
        if (n == 6 || n == 7) return {2{wd[15:0]}};
        if (c == WRITE_DWORD) return wd;
        return 32'h0;
    endfunction

    task automatic check_pulses();
        chk("readValid", 32'(readValid), 32'(exp_rv));
        chk("busTimeout", 32'(busTimeout), 32'(exp_to));
        chk("readData", readData, model_rdata);
        exp_rv = 1'b0;
        exp_to = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        transactionControl = NO_OP;
        busAck = 1'($urandom_range(0, 1));
        busReadData = $urandom;
        address = $urandom;
        writeData = $urandom;
        #1;
        check_pulses();
        chk("idle_strobes", 32'({busRead, busWrite}), 32'h0);
        chk("idle_stall", 32'(stall), 32'h0);
    endtask

    task automatic run_txn(input controlBus c, input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd);
        logic ack;
        @(negedge clk);
        transactionControl = c;
        address = a;
        writeData = wd;
        busAck = 1'($urandom_range(0, 1));
        busReadData = $urandom;
        #1;
        check_pulses();
        chk("cmd_strobes", 32'({busRead, busWrite}), 32'h0);
        chk("cmd_stall", 32'(stall), 32'h1);
        for (int k = 0; k < T; k++) begin
            @(negedge clk);
            transactionControl = controlBus'(4'($urandom_range(0, 8)));
            address = $urandom;
            writeData = $urandom;
            ack = (k == ack_at);
            busAck = ack;
            busReadData = ack ? rd : $urandom;
            #1;
            check_pulses();
            chk("busAddress", 32'(busAddress), 32'(a[31:2]));
            chk("busByteEnable", 32'(busByteEnable), 32'(exp_be(c)));
            chk("busWriteData", busWriteData, exp_wdata(c, wd));
            chk("busRead", 32'(busRead), 32'(c == READ));
            chk("busWrite", 32'(busWrite), 32'(c != READ));
            chk("bus_stall", 32'(stall), 32'(!ack && (k != T - 1)));
            if (ack) begin
                if (c == READ) begin
                    model_rdata = rd;
                    exp_rv = 1'b1;
                end
                break;
            end
            if (k == T - 1) exp_to = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        transactionControl = READ;
        address = 32'h0;
        writeData = 32'h0;
        busReadData = 32'h0;
        busAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_strobes", 32'({busRead, busWrite, busByteEnable}), 32'h0);
        chk("rst_addr", 32'(busAddress), 32'h0);
        chk("rst_wdata", busWriteData, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        check_pulses();
        @(negedge clk);
        reset = 1'b1;
        transactionControl = NO_OP;

        // Read with three wait cycles, then a byte write, then back-to-back writes.
        run_txn(READ, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF);
        run_txn(WRITE_BYTE2, 32'h0000_2002, 32'h0000_00A5, 0, 32'h0);
        run_txn(WRITE_WORD1, 32'h0000_3000, 32'h1234_5678, 0, 32'h0);
        run_txn(WRITE_DWORD, 32'h0000_3004, 32'hCAFE_F00D, 0, 32'h0);
        // Unacked read times out; then an ack on the last allowed cycle completes.
        run_txn(READ, 32'h0000_4000, 32'h0, NEVER, 32'h0);
        run_txn(READ, 32'h0000_4004, 32'h0, T - 1, 32'h5555_AAAA);
        idle_cycle();
        idle_cycle();

        // Reset during the second BUS cycle of a write.
        @(negedge clk);
        transactionControl = WRITE_WORD0;
        address = 32'h0000_5000;
        writeData = 32'h0000_BEEF;
        busAck = 1'b0;
        #1;
        check_pulses();
        @(negedge clk);
        transactionControl = NO_OP;
        #1;
        chk("mid_write0", 32'(busWrite), 32'h1);
        @(negedge clk);
        #1;
        chk("mid_write1", 32'(busWrite), 32'h1);
        reset = 1'b0;
        transactionControl = READ;
        #1;
        model_rdata = 32'h0;
        chk("arst_write", 32'(busWrite), 32'h0);
        chk("arst_be", 32'(busByteEnable), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        check_pulses();
        @(negedge clk);
        reset = 1'b1;
        transactionControl = NO_OP;
        run_txn(READ, 32'h0000_6008, 32'h0, 1, 32'h0BAD_CAFE);

        for (int i = 0; i < 40; i++) begin
            run_txn(controlBus'(4'($urandom_range(1, 8))), $urandom, $urandom,
                    $urandom_range(0, T), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_transaction_logic.md
BUS_TRANSACTION_LOGIC -- requirements
Module: bus_transaction_logic

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of BUS-state cycles without busAck before the transaction is abandoned; legal range 1..255.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 transactionControl  input  transactionGroup::controlBus  command from the controller's registered transaction output: NO_OP, READ, WRITE_BYTE0..3, WRITE_WORD0/1, WRITE_DWORD.
REQ-006 address  input  32  byte address of the access.
REQ-007 writeData  input  32  store data, right-aligned.
REQ-008 busAddress  output  30  word address, address[31:2].
REQ-009 busByteEnable  output  4  active byte lanes.
REQ-010 busRead / busWrite  output  1 each  bus strobes.
REQ-011 busWriteData  output  32  lane-aligned store data.
REQ-012 busReadData  input  32  read data, sampled on busAck.
REQ-013 busAck  input  1  slave completion, single-cycle.
REQ-014 readData  output  32  captured read word.
REQ-015 readValid  output  1  one-cycle pulse when readData is updated.
REQ-016 stall  output  1  active-high hold request; the controller's enable is driven from its inverse.
REQ-017 busTimeout  output  1  one-cycle pulse when a transaction is abandoned.

Function
REQ-018 States: IDLE and BUS.
- IDLE to BUS on any command other than NO_OP.
- BUS to IDLE on busAck or on timeout.
REQ-019 On IDLE to BUS, the block SHALL latch the command, address[31:2], and the lane-aligned data. All bus outputs SHALL be registered and first asserted in the cycle after the command is seen.
REQ-020 In BUS, commands SHALL be ignored. All bus outputs SHALL hold constant until exit.
REQ-021 Byte enables:
- READ = 1111
- WRITE_BYTE0..3 = 0001 / 0010 / 0100 / 1000
- WRITE_WORD0 = 0011, WRITE_WORD1 = 1100
- WRITE_DWORD = 1111
REQ-022 busWriteData:
- byte writes: writeData[7:0] replicated on all four lanes.
- word writes: writeData[15:0] replicated on both halves.
- WRITE_DWORD: writeData unchanged.
- READ: 0.
REQ-023 busRead=1 only for READ. busWrite=1 only for write commands. Both SHALL be 0 in IDLE.
REQ-024 stall SHALL be combinational, equal to (IDLE and command not NO_OP) or (BUS and not busAck).
REQ-025 On busAck in BUS during a READ, readData SHALL load busReadData and readValid SHALL pulse high for exactly the next cycle. A write ack SHALL leave readData unchanged and produce no readValid.
REQ-026 Minimum transaction: command at cycle N, bus strobe at N+1, ack at N+1, readValid at N+2. A new command MAY be accepted at N+2 (back-to-back).
REQ-027 Cycle counter:
- cleared on BUS entry; increments each BUS cycle without busAck.
- when it reaches TIMEOUT_CYCLES-1 without ack, the next edge SHALL return to IDLE and pulse busTimeout for one cycle.
- stall SHALL be 0 in the final timeout cycle.
- no readValid on timeout; readData unchanged.
REQ-028 busAck in the same cycle as the timeout condition SHALL be treated as a normal ack; no busTimeout.
REQ-029 busAck while in IDLE SHALL be ignored.

Reset
REQ-030 While reset=0, all of the following SHALL be forced asynchronously, including mid-transaction: state=IDLE, busRead=busWrite=0, busByteEnable=0, busAddress=0, busWriteData=0, readData=0, readValid=0, busTimeout=0, counter=0.
REQ-031 stall SHALL be 0 during reset regardless of transactionControl.
REQ-032 After reset release, the first command SHALL be accepted on the first rising edge.

Verification
REQ-033 READ at address 0x0000_1004, slave acks after 3 wait cycles with 0xDEAD_BEEF -> busAddress=0x0000_0401, busByteEnable=1111, busRead=1, stall high 4 cycles, readData=0xDEAD_BEEF with one readValid pulse.
REQ-034 WRITE_BYTE2 with writeData=0x0000_00A5, immediate ack -> busByteEnable=0100, busWriteData=0xA5A5_A5A5, busWrite=1 for 1 cycle, no readValid.
REQ-035 WRITE_WORD1 then WRITE_DWORD back-to-back, each acked in its first BUS cycle -> enables 1100 then 1111, one idle cycle between strobes, no lost command.
REQ-036 TIMEOUT_CYCLES=4, READ never acked -> busRead high 4 cycles, busTimeout pulses once, readData unchanged, state IDLE; then ack on exactly the 4th cycle -> normal completion, no busTimeout.
REQ-037 reset driven low during the 2nd BUS cycle of a write -> busWrite and busByteEnable drop immediately, not waiting for clk; stall=0; after release a READ completes normally.
